// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Definitions shared by the UART transmitter and receiver:
//                the receiver state encoding and the frame line levels
//                (start = 0, stop = 1, idle = 1).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_rx_state_t;

    localparam logic C_START_LEVEL = 1'b0;
    localparam logic C_STOP_LEVEL  = 1'b1;
    localparam logic C_IDLE_LEVEL  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rx_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_shift_reg
//  Description : Right-shift register with MSB insertion. After DATA_BITS
//                shifts of an LSB-first stream, the first bit received is
//                in dout[0].
//  Ports       : clk   - clock
//                rst_n - asynchronous active-low reset (clears dout)
//                shift - shift enable
//                din   - bit inserted at the MSB
//                dout  - register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_shift_reg #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 shift,
    input  logic                 din,
    output logic [DATA_BITS-1:0] dout
);

    generate
        if (DATA_BITS == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout <= '0;
                end else if (shift) begin
                    dout <= din;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout <= '0;
                end else if (shift) begin
                    dout <= {din, dout[DATA_BITS-1:1]};
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Unbuffered UART receiver. Frame: one low start bit,
//                DATA_BITS data bits LSB first, optional even-parity bit,
//                one high stop bit. Each received word is presented with a
//                one-cycle valid or frame_err pulse.
//  Config      : UART_RX_PARITY_EN - when defined, an even-parity bit is
//                expected between the data bits and the stop bit.
//  Ports       : clk        - clock, all logic on posedge
//                rst_n      - asynchronous active-low reset
//                rx         - asynchronous serial line, idles high
//                data       - last received word, held until next frame
//                valid      - one-cycle pulse, good frame received
//                frame_err  - one-cycle pulse, stop bit sampled low
//                parity_err - one-cycle pulse, parity mismatch
//                busy       - high while not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 4,
    parameter int DATA_BITS      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CW   = $clog2(CLOCKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam int HALF = (CLOCKS_PER_BIT - 1) / 2;

    localparam logic [CW-1:0] C_HALF     = CW'(HALF);
    localparam logic [CW-1:0] C_LAST     = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [BW-1:0] C_LAST_BIT = BW'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    uart_rx_state_t       r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic                 w_shift;
    logic [DATA_BITS-1:0] w_shift_dout;
`ifdef UART_RX_PARITY_EN
    logic                 r_parity;
    logic                 r_parity_err;
`endif

    // Two-flop synchroniser plus one delayed copy for edge detection.
    // Resetting to the idle level keeps reset release from looking like
    // a start-bit falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= C_IDLE_LEVEL;
            r_rx_s    <= C_IDLE_LEVEL;
            r_rx_prev <= C_IDLE_LEVEL;
        end else begin
            r_sync1   <= rx;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_shift = (r_state == ST_DATA) && (r_cnt == C_LAST);

    rx_shift_reg #(
        .DATA_BITS (DATA_BITS)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (w_shift),
        .din   (r_rx_s),
        .dout  (w_shift_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity     <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    // Edge-triggered so a line held low (break) cannot
                    // start a new frame.
                    if (r_rx_s == C_START_LEVEL && r_rx_prev == C_IDLE_LEVEL) begin
                        r_state <= ST_START;
                        busy    <= 1'b1;
                    end
                end

                ST_START: begin
                    if (r_cnt == C_HALF) begin
                        // Counter restarts here, so subsequent samples land
                        // at the centre of each bit.
                        r_cnt <= '0;
                        if (r_rx_s == C_START_LEVEL) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            r_parity  <= 1'b0;
`endif
                        end else begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                        r_parity <= r_parity ^ r_rx_s;
`endif
                        if (r_bit_cnt == C_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt    <= '0;
                        r_parity <= r_parity ^ r_rx_s;
                        r_state  <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    if (r_cnt == C_LAST) begin
                        // Leave at mid-stop-bit so a back-to-back start bit
                        // is seen by the idle edge detector.
                        r_cnt     <= '0;
                        r_state   <= ST_IDLE;
                        busy      <= 1'b0;
                        data      <= w_shift_dout;
                        valid     <= (r_rx_s == C_STOP_LEVEL);
                        frame_err <= (r_rx_s != C_STOP_LEVEL);
`ifdef UART_RX_PARITY_EN
                        r_parity_err <= r_parity;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx with default
//                parameters. Parity scenarios are compiled in when
//                UART_RX_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB  = 4;
    localparam int DB   = 8;
    localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    // Completion pulse is observed in the cycle after edge F + LAT.
    localparam int LAT       = 3 + HALF + (DB + 1 + NPAR) * CPB;
    localparam int FRAME_CYC = (DB + 2 + NPAR) * CPB;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx    = 1'b1;
    logic [DB-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          parity_err;
    logic          busy;

    uart_rx #(
        .CLOCKS_PER_BIT (CPB),
        .DATA_BITS      (DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    int            v_cnt = 0, v_last_cyc = 0, e_cnt = 0, e_last_cyc = 0;
    int            p_cnt = 0, b_rise_cnt = 0, b_rise_cyc = 0, b_fall_cyc = 0;
    logic          p_last = 1'b0;
    logic          prev_busy = 1'b0;
    logic [DB-1:0] v_q[$];
    int            vc_q[$];

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            v_cnt++;
            v_last_cyc = cyc;
            v_q.push_back(data);
            vc_q.push_back(cyc);
            p_last = parity_err;
        end
        if (frame_err === 1'b1) begin
            e_cnt++;
            e_last_cyc = cyc;
        end
        if (parity_err === 1'b1) p_cnt++;
        if (busy === 1'b1 && !prev_busy) begin
            b_rise_cnt++;
            b_rise_cyc = cyc;
        end
        if (busy !== 1'b1 && prev_busy) b_fall_cyc = cyc;
        prev_busy = (busy === 1'b1);
    end

`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    // Called #1 after a posedge; returns #1 after a posedge.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DB-1:0] w, input logic stop_b, output int f);
        f = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(w[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^w) ^ par_flip);
`endif
        drive_bit(stop_b);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, f1, f2, v0, e0, b0, qi;
        logic [DB-1:0] w;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_perr", 32'(parity_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        idle(5);

        // Frame 0xA5
        v0 = v_cnt; e0 = e_cnt;
        send_frame(8'hA5, 1'b1, f);
        idle(10);
        chk("a5_valid_cnt", 32'(v_cnt - v0), 32'd1);
        chk("a5_valid_cyc", 32'(v_last_cyc), 32'(f + LAT));
        chk("a5_data", 32'(data), 32'hA5);
        chk("a5_ferr_cnt", 32'(e_cnt - e0), 32'd0);
        chk("a5_busy_rise", 32'(b_rise_cyc), 32'(f + 2));
        chk("a5_busy_fall", 32'(b_fall_cyc), 32'(f + LAT));
        chk("a5_busy_after", 32'(busy), 32'h0);

        // One-cycle glitch
        v0 = v_cnt; e0 = e_cnt;
        f = cyc + 1;
        rx = 1'b0;
        @(posedge clk);
        #1;
        idle(12);
        chk("gl_busy_rise", 32'(b_rise_cyc), 32'(f + 2));
        chk("gl_busy_fall", 32'(b_fall_cyc), 32'(f + 2 + HALF + 1));
        chk("gl_valid_cnt", 32'(v_cnt - v0), 32'd0);
        chk("gl_ferr_cnt", 32'(e_cnt - e0), 32'd0);
        chk("gl_data", 32'(data), 32'hA5);

        // Bad stop bit followed by a long break
        v0 = v_cnt; e0 = e_cnt; b0 = b_rise_cnt;
        send_frame(8'h3C, 1'b0, f);
        rx = 1'b0;
        repeat (20 * CPB) @(posedge clk);
        #1;
        idle(10);
        chk("brk_ferr_cnt", 32'(e_cnt - e0), 32'd1);
        chk("brk_ferr_cyc", 32'(e_last_cyc), 32'(f + LAT));
        chk("brk_valid_cnt", 32'(v_cnt - v0), 32'd0);
        chk("brk_data", 32'(data), 32'h3C);
        chk("brk_busy_rises", 32'(b_rise_cnt - b0), 32'd1);

        // Back-to-back 0x00, 0xFF
        v0 = v_cnt; qi = v_q.size();
        send_frame(8'h00, 1'b1, f1);
        send_frame(8'hFF, 1'b1, f2);
        idle(10);
        chk("b2b_valid_cnt", 32'(v_cnt - v0), 32'd2);
        chk("b2b_data0", 32'(v_q[qi]), 32'h00);
        chk("b2b_data1", 32'(v_q[qi+1]), 32'hFF);
        chk("b2b_cyc0", 32'(vc_q[qi]), 32'(f1 + LAT));
        chk("b2b_gap", 32'(vc_q[qi+1] - vc_q[qi]), 32'(FRAME_CYC));

        // Reset during data bit 4
        v0 = v_cnt; e0 = e_cnt;
        w = 8'h96;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(w[i]);
        rx = w[4];
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        chk("mid_rst_data", 32'(data), 32'h0);
        chk("mid_rst_valid", 32'(valid), 32'h0);
        chk("mid_rst_ferr", 32'(frame_err), 32'h0);
        chk("mid_rst_perr", 32'(parity_err), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(LAT + 10);
        chk("mid_no_valid", 32'(v_cnt - v0), 32'd0);
        chk("mid_no_ferr", 32'(e_cnt - e0), 32'd0);
        send_frame(8'h5A, 1'b1, f);
        idle(10);
        chk("post_valid_cnt", 32'(v_cnt - v0), 32'd1);
        chk("post_valid_cyc", 32'(v_last_cyc), 32'(f + LAT));
        chk("post_data", 32'(data), 32'h5A);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1
        v0 = v_cnt;
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1, f);
        idle(10);
        chk("par_ok_valid", 32'(v_cnt - v0), 32'd1);
        chk("par_ok_perr", 32'(p_last), 32'h0);
        chk("par_ok_data", 32'(data), 32'h07);
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, f);
        idle(10);
        par_flip = 1'b0;
        chk("par_bad_valid", 32'(v_cnt - v0), 32'd2);
        chk("par_bad_perr", 32'(p_last), 32'h1);
`endif
        chk("perr_total", 32'(p_cnt), 32'(NPAR));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
